// File: rtl/maxpool_2x2.sv
// maxpool_2x2: 2x2 stride-2 max-pooling stage on a raster pixel stream.
// Accepts one pixel per clock when valid_in is high (no backpressure) and
// emits one pooled pixel per complete 2x2 block, in raster order.
// Even-row horizontal maxima wait in a half-width line buffer for the odd row.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   pxl_in      input pixel, sampled when valid_in=1
//   valid_in    input strobe
//   pxl_out     pooled pixel (registered)
//   valid       one-cycle qualifier for pxl_out (registered)
//   frame_done  one-cycle pulse after the last pixel of a frame is accepted
module maxpool_2x2 #(
   parameter int unsigned IMG_W = 218,
   parameter int unsigned IMG_H = 218,
   parameter int unsigned DW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] pxl_in,
   input  logic          valid_in,
   output logic [DW-1:0] pxl_out,
   output logic          valid,
   output logic          frame_done
);

   localparam int unsigned CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int unsigned RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int unsigned BUF_N = (IMG_W / 2 > 0) ? IMG_W / 2 : 1;
   localparam int unsigned BW    = (BUF_N > 1) ? $clog2(BUF_N) : 1;

   logic [CW-1:0] col;
   logic [RW-1:0] row;
   logic [DW-1:0] h_reg;
   logic [DW-1:0] line_buf [BUF_N];

   logic          last_col;
   logic          last_row;
   logic [BW-1:0] buf_idx;
   logic [DW-1:0] buf_rd;
   logic [DW-1:0] hmax;
   logic [DW-1:0] vmax;

   // Position decode, line-buffer read and unsigned max trees.
   // buf_idx may point past the buffer only on the unused even last column of an odd-width frame.
   always_comb begin
      last_col = (col == CW'(IMG_W - 1));
      last_row = (row == RW'(IMG_H - 1));
      buf_idx  = BW'(col >> 1);
      buf_rd   = line_buf[buf_idx];
      hmax     = (pxl_in > h_reg) ? pxl_in : h_reg;
      vmax     = (hmax > buf_rd) ? hmax : buf_rd;
   end

   // Even rows park their horizontal maxima; the odd row below reads them back.
   always_ff @(posedge clk) begin
      if (valid_in && col[0] && !row[0]) begin
         line_buf[buf_idx] <= hmax;
      end
   end

   // Raster counters, horizontal holding register and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col        <= '0;
         row        <= '0;
         h_reg      <= '0;
         pxl_out    <= '0;
         valid      <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         valid      <= 1'b0;
         frame_done <= 1'b0;
         if (valid_in) begin
            if (last_col) begin
               col <= '0;
               row <= last_row ? '0 : row + RW'(1);
            end else begin
               col <= col + CW'(1);
            end
            if (!col[0]) begin
               h_reg <= pxl_in;
            end
            if (col[0] && row[0]) begin
               pxl_out <= vmax;
               valid   <= 1'b1;
            end
            frame_done <= last_col && last_row;
         end
      end
   end

endmodule

// File: tb/tb_maxpool_2x2.sv
module tb_maxpool_2x2;

   localparam int unsigned DW = 8;
   localparam int unsigned BW_IMG = 218;
   localparam int unsigned BH_IMG = 218;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic [DW-1:0] p4, p5, pd, pb;
   logic          v4, v5, vd, vb;
   logic [DW-1:0] o4p, o5p, odp, obp;
   logic          o4v, o5v, odv, obv;
   logic          o4f, o5f, odf, obf;

   maxpool_2x2 #(.IMG_W(4), .IMG_H(4), .DW(DW)) u4 (
      .clk(clk), .reset(rst_n), .pxl_in(p4), .valid_in(v4),
      .pxl_out(o4p), .valid(o4v), .frame_done(o4f));

   maxpool_2x2 #(.IMG_W(5), .IMG_H(5), .DW(DW)) u5 (
      .clk(clk), .reset(rst_n), .pxl_in(p5), .valid_in(v5),
      .pxl_out(o5p), .valid(o5v), .frame_done(o5f));

   maxpool_2x2 #(.IMG_W(BW_IMG), .IMG_H(BH_IMG), .DW(DW)) ud (
      .clk(clk), .reset(rst_n), .pxl_in(pd), .valid_in(vd),
      .pxl_out(odp), .valid(odv), .frame_done(odf));

   maxpool_2x2 #(.IMG_W(BW_IMG), .IMG_H(BH_IMG), .DW(DW)) ub (
      .clk(clk), .reset(rst_n), .pxl_in(pb), .valid_in(vb),
      .pxl_out(obp), .valid(obv), .frame_done(obf));

   int n_pass  = 0;
   int n_total = 0;

   logic [DW-1:0] q4[$], q5[$], qd[$], qb[$];
   bit            q4fd[$];
   int            fd4 = 0, fd5 = 0, fdd = 0, fdb = 0;
   int            br_b = 0;
   bit            dbl_err = 0;

   logic [DW-1:0] frame [BW_IMG*BH_IMG];
   logic [DW-1:0] expq[$];

   // Output capture, sampled mid-cycle.
   always @(negedge clk) begin
      if (o4v) begin q4.push_back(o4p); q4fd.push_back(o4f); end
      if (o4f) fd4++;
      if (o5v) q5.push_back(o5p);
      if (o5f) fd5++;
      if (odv) qd.push_back(odp);
      if (odf) fdd++;
      if (obv) begin
         if (qb.size() >= br_b) dbl_err = 1;
         qb.push_back(obp);
      end
      if (obf) fdb++;
   end

   task automatic send4(input logic [DW-1:0] p);
      p4 = p; v4 = 1'b1;
      @(posedge clk); #1;
      v4 = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic clear4();
      q4.delete(); q4fd.delete(); fd4 = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      p4 = '0; p5 = '0; pd = '0; pb = '0;
      v4 = 1'b0; v5 = 1'b0; vd = 1'b0; vb = 1'b0;
      idle(3);
      n_total++;
      if ({o4v, o4f, o4p} !== '0) $display("FAIL reset_u4 got v=%b f=%b p=%0d want 0", o4v, o4f, o4p);
      else n_pass++;
      n_total++;
      if ({o5v, o5f, o5p, odv, odf, odp, obv, obf, obp} !== '0)
         $display("FAIL reset_others got nonzero outputs want 0");
      else n_pass++;
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_basic4();
      logic [DW-1:0] e[4] = '{5, 7, 13, 15};
      clear4();
      for (int i = 0; i < 16; i++) send4(DW'(i));
      idle(3);
      n_total++;
      if (q4.size() != 4) $display("FAIL basic4_count got %0d want 4", q4.size());
      else n_pass++;
      for (int i = 0; i < 4 && i < q4.size(); i++) begin
         n_total++;
         if (q4[i] !== e[i]) $display("FAIL basic4_pix[%0d] got %0d want %0d", i, q4[i], e[i]);
         else n_pass++;
         n_total++;
         if (q4fd[i] !== (i == 3)) $display("FAIL basic4_fd_align[%0d] got %b want %b", i, q4fd[i], i == 3);
         else n_pass++;
      end
      n_total++;
      if (fd4 != 1) $display("FAIL basic4_fd_count got %0d want 1", fd4);
      else n_pass++;
   endtask

   task automatic test_odd_size();
      logic [DW-1:0] e[4] = '{6, 8, 16, 18};
      q5.delete(); fd5 = 0;
      for (int i = 0; i < 25; i++) begin
         p5 = DW'(i); v5 = 1'b1;
         @(posedge clk); #1;
      end
      v5 = 1'b0;
      n_total++;
      if (o5f !== 1'b1) $display("FAIL odd_fd_timing got %b want 1", o5f);
      else n_pass++;
      idle(3);
      n_total++;
      if (q5.size() != 4) $display("FAIL odd_count got %0d want 4", q5.size());
      else n_pass++;
      for (int i = 0; i < 4 && i < q5.size(); i++) begin
         n_total++;
         if (q5[i] !== e[i]) $display("FAIL odd_pix[%0d] got %0d want %0d", i, q5[i], e[i]);
         else n_pass++;
      end
      n_total++;
      if (fd5 != 1) $display("FAIL odd_fd_count got %0d want 1", fd5);
      else n_pass++;
   endtask

   task automatic test_unsigned();
      logic [DW-1:0] f[16] = '{128, 255, 200, 10,
                               0,   127, 0,   0,
                               0,   0,   0,   0,
                               0,   0,   0,   0};
      logic [DW-1:0] e[4] = '{255, 200, 0, 0};
      clear4();
      for (int i = 0; i < 16; i++) send4(f[i]);
      idle(3);
      n_total++;
      if (q4.size() != 4) $display("FAIL unsigned_count got %0d want 4", q4.size());
      else n_pass++;
      for (int i = 0; i < 4 && i < q4.size(); i++) begin
         n_total++;
         if (q4[i] !== e[i]) $display("FAIL unsigned_pix[%0d] got %0d want %0d", i, q4[i], e[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_midframe();
      logic [DW-1:0] e[4] = '{5, 7, 13, 15};
      for (int i = 0; i < 100; i++) send4(DW'($urandom_range(255)));
      rst_n = 1'b0;
      clear4();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_total++;
         if ({o4v, o4f, o4p} !== '0)
            $display("FAIL midreset_hold[%0d] got v=%b f=%b p=%0d want 0", k, o4v, o4f, o4p);
         else n_pass++;
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      clear4();
      for (int i = 0; i < 16; i++) send4(DW'(i));
      idle(3);
      n_total++;
      if (q4.size() != 4) $display("FAIL midreset_count got %0d want 4", q4.size());
      else n_pass++;
      for (int i = 0; i < 4 && i < q4.size(); i++) begin
         n_total++;
         if (q4[i] !== e[i]) $display("FAIL midreset_pix[%0d] got %0d want %0d", i, q4[i], e[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] e[8] = '{5, 7, 13, 15, 21, 23, 29, 31};
      clear4();
      for (int i = 0; i < 32; i++) send4(DW'(i));
      idle(3);
      n_total++;
      if (q4.size() != 8) $display("FAIL b2b_count got %0d want 8", q4.size());
      else n_pass++;
      for (int i = 0; i < 8 && i < q4.size(); i++) begin
         n_total++;
         if (q4[i] !== e[i]) $display("FAIL b2b_pix[%0d] got %0d want %0d", i, q4[i], e[i]);
         else n_pass++;
      end
      n_total++;
      if (fd4 != 2) $display("FAIL b2b_fd_count got %0d want 2", fd4);
      else n_pass++;
   endtask

   // Reference: max of each complete 2x2 block in raster order.
   task automatic build_model();
      int npix;
      logic [DW-1:0] m;
      npix = int'(BW_IMG * BH_IMG);
      for (int k = 0; k < npix; k++) frame[k] = DW'($urandom_range(255));
      expq.delete();
      for (int br = 0; br < int'(BH_IMG / 2); br++) begin
         for (int bc = 0; bc < int'(BW_IMG / 2); bc++) begin
            m = 0;
            for (int dy = 0; dy < 2; dy++)
               for (int dx = 0; dx < 2; dx++)
                  if (frame[(2*br+dy)*int'(BW_IMG) + 2*bc+dx] > m)
                     m = frame[(2*br+dy)*int'(BW_IMG) + 2*bc+dx];
            expq.push_back(m);
         end
      end
   endtask

   task automatic test_random_frames();
      int npix;
      int nbad_d, nbad_b;
      npix = int'(BW_IMG * BH_IMG);
      build_model();
      qd.delete(); qb.delete(); fdd = 0; fdb = 0; br_b = 0; dbl_err = 0;
      fork
         begin
            for (int k = 0; k < npix; k++) begin
               pd = frame[k]; vd = 1'b1;
               @(posedge clk); #1;
            end
            vd = 1'b0;
         end
         begin
            for (int k = 0; k < npix; k++) begin
               while ($urandom_range(99) < 30) begin
                  vb = 1'b0; pb = DW'($urandom_range(255));
                  @(posedge clk); #1;
               end
               pb = frame[k]; vb = 1'b1;
               if (((k / int'(BW_IMG)) % 2 == 1) && ((k % int'(BW_IMG)) % 2 == 1)) br_b++;
               @(posedge clk); #1;
            end
            vb = 1'b0;
         end
      join
      idle(4);
      n_total++;
      if (qd.size() != expq.size()) $display("FAIL rand_count got %0d want %0d", qd.size(), expq.size());
      else n_pass++;
      n_total++;
      if (qb.size() != expq.size()) $display("FAIL bubble_count got %0d want %0d", qb.size(), expq.size());
      else n_pass++;
      nbad_d = 0; nbad_b = 0;
      for (int i = 0; i < expq.size(); i++) begin
         if (i < qd.size()) begin
            n_total++;
            if (qd[i] !== expq[i]) begin
               if (nbad_d < 5) $display("FAIL rand_pix[%0d] got %0d want %0d", i, qd[i], expq[i]);
               nbad_d++;
            end else n_pass++;
         end
         if (i < qb.size()) begin
            n_total++;
            if (qb[i] !== expq[i]) begin
               if (nbad_b < 5) $display("FAIL bubble_pix[%0d] got %0d want %0d", i, qb[i], expq[i]);
               nbad_b++;
            end else n_pass++;
         end
      end
      n_total++;
      if (fdd != 1) $display("FAIL rand_fd_count got %0d want 1", fdd);
      else n_pass++;
      n_total++;
      if (fdb != 1) $display("FAIL bubble_fd_count got %0d want 1", fdb);
      else n_pass++;
      n_total++;
      if (dbl_err !== 1'b0) $display("FAIL bubble_extra_valid got %b want 0", dbl_err);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic4();
      test_odd_size();
      test_unsigned();
      test_reset_midframe();
      test_back_to_back();
      test_random_frames();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
